// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_pkg
// Brief    : Command and read-FSM encodings shared by the SPI slave and RAM ctrl
// Revision : 1.0
// ============================================================================
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [0:0] {
        RD_IDLE  = 1'b0,
        RD_ARMED = 1'b1
    } rd_state_e;

endpackage : spi_ram_pkg
`default_nettype wire

// File: rtl/sp_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_array
// Brief    : MEM_DEPTH x 8 storage, synchronous write, combinational read
// Revision : 1.0
// ============================================================================
module sp_ram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [7:0]           rdata
);

    logic [7:0] r_mem [MEM_DEPTH];

    // Contents are deliberately not reset; the caller range-checks both ports.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : sp_ram_array
`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_ctrl
// Brief    : Decodes SPI slave frames into address-load/write/read RAM commands
// Revision : 1.0
// ============================================================================
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [9:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       seq_err
);

    localparam logic [ADDR_SIZE:0] c_MEM_DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);

    rd_state_e            r_rd_state;
    rd_state_e            w_rd_state_nxt;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;
    logic                 r_seq_err;

    logic [ADDR_SIZE-1:0] w_wr_addr_nxt;
    logic [ADDR_SIZE-1:0] w_rd_addr_nxt;
    logic [7:0]           w_tx_data_nxt;
    logic                 w_tx_valid_nxt;
    logic                 w_seq_err_nxt;
    logic                 w_we;
    logic [7:0]           w_rdata;

    logic [1:0]           w_cmd;
    logic [7:0]           w_payload;
    logic [ADDR_SIZE-1:0] w_addr_in;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;

    assign w_cmd         = rx_data[9:8];
    assign w_payload     = rx_data[7:0];
    assign w_addr_in     = rx_data[ADDR_SIZE-1:0];
    assign w_wr_in_range = ({1'b0, r_wr_addr} < c_MEM_DEPTH);
    assign w_rd_in_range = ({1'b0, r_rd_addr} < c_MEM_DEPTH);

    sp_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_addr),
        .wdata (w_payload),
        .raddr (r_rd_addr),
        .rdata (w_rdata)
    );

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_wr_addr_nxt  = r_wr_addr;
        w_rd_addr_nxt  = r_rd_addr;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = 1'b0;
        w_seq_err_nxt  = 1'b0;
        w_we           = 1'b0;
        if (rx_valid) begin
            case (w_cmd)
                CMD_WR_ADDR: w_wr_addr_nxt = w_addr_in;
                CMD_WR_DATA: w_we = w_wr_in_range;
                CMD_RD_ADDR: begin
                    w_rd_addr_nxt  = w_addr_in;
                    w_rd_state_nxt = RD_ARMED;
                end
                CMD_RD_DATA: begin
                    // Unarmed reads still execute; seq_err only flags the protocol slip.
                    w_tx_data_nxt  = w_rd_in_range ? w_rdata : 8'h00;
                    w_tx_valid_nxt = 1'b1;
                    w_seq_err_nxt  = (r_rd_state == RD_IDLE);
                    w_rd_state_nxt = RD_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_wr_addr  <= w_wr_addr_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_seq_err  <= w_seq_err_nxt;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign seq_err  = r_seq_err;

endmodule : spi_ram_ctrl
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ram_ctrl
// Brief    : Directed and random frame stimulus against a behavioural RAM model
// Revision : 1.0
// ============================================================================
module tb_spi_ram_ctrl;

    localparam int DEPTH = 200;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       seq_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] m_mem [256];
    int         m_wr;
    int         m_rd;
    bit         m_armed;
    logic [7:0] exp_td;
    logic       exp_tv;
    logic       exp_se;

    spi_ram_ctrl #(
        .MEM_DEPTH (DEPTH),
        .ADDR_SIZE (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .seq_err  (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_armed = 0;
        exp_td = 8'h00; exp_tv = 1'b0; exp_se = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] cmd, input logic [7:0] pl);
        rx_valid = 1'b1;
        rx_data  = {cmd, pl};
        @(posedge clk);
        #1;
        exp_tv = 1'b0;
        exp_se = 1'b0;
        case (cmd)
            2'b00: m_wr = int'(pl);
            2'b01: if (m_wr < DEPTH) m_mem[m_wr] = pl;
            2'b10: begin m_rd = int'(pl); m_armed = 1; end
            default: begin
                exp_tv  = 1'b1;
                exp_se  = !m_armed;
                exp_td  = (m_rd < DEPTH) ? m_mem[m_rd] : 8'h00;
                m_armed = 0;
            end
        endcase
    endtask

    task automatic idle_cycle();
        rx_valid = 1'b0;
        rx_data  = 10'($urandom);
        @(posedge clk);
        #1;
        exp_tv = 1'b0;
        exp_se = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b1; rx_data = 10'h3FF;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++;
        if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
        checks++;
        rst = 1'b0; rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_rw();
        send_frame(2'b00, 8'hA5); idle_cycle();
        send_frame(2'b01, 8'h3C); idle_cycle();
        send_frame(2'b10, 8'hA5); idle_cycle();
        send_frame(2'b11, 8'h00);
        if (tx_valid !== 1'b1 || tx_data !== 8'h3C || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_read: got tv=%b td=%h se=%b expected tv=1 td=3c se=0", tx_valid, tx_data, seq_err);
        end
        checks++;
        idle_cycle();
        if (tx_valid !== 1'b0 || tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL basic_hold: got tv=%b td=%h expected tv=0 td=3c", tx_valid, tx_data);
        end
        checks++;
    endtask

    // Give every in-range location a known value so later reads are predictable.
    task automatic test_fill();
        for (int a = 0; a < DEPTH; a++) begin
            send_frame(2'b00, 8'(a));
            send_frame(2'b01, 8'($urandom));
        end
        idle_cycle();
        for (int k = 0; k < 8; k++) begin
            send_frame(2'b10, 8'($urandom_range(0, DEPTH - 1)));
            send_frame(2'b11, 8'($urandom));
            if (tx_data !== exp_td || tx_valid !== 1'b1 || seq_err !== 1'b0) begin
                errors++;
                $display("FAIL fill_read%0d: got tv=%b td=%h se=%b expected tv=1 td=%h se=0", k, tx_valid, tx_data, seq_err, exp_td);
            end
            checks++;
        end
        idle_cycle();
    endtask

    task automatic test_double_read();
        logic [7:0] first;
        send_frame(2'b10, 8'h21);
        send_frame(2'b11, 8'h00);
        first = tx_data;
        if (first !== exp_td || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL dbl_first: got td=%h se=%b expected td=%h se=0", first, seq_err, exp_td);
        end
        checks++;
        send_frame(2'b11, 8'h00);
        if (tx_data !== exp_td || tx_valid !== 1'b1 || seq_err !== 1'b1) begin
            errors++;
            $display("FAIL dbl_second: got tv=%b td=%h se=%b expected tv=1 td=%h se=1", tx_valid, tx_data, seq_err, exp_td);
        end
        checks++;
        idle_cycle();
        if (seq_err !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL dbl_clear: got tv=%b se=%b expected tv=0 se=0", tx_valid, seq_err);
        end
        checks++;
    endtask

    task automatic test_out_of_range();
        send_frame(2'b00, 8'hC8);
        send_frame(2'b01, 8'h55);
        send_frame(2'b10, 8'hC8);
        send_frame(2'b11, 8'h00);
        if (tx_data !== 8'h00 || tx_valid !== 1'b1 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_read: got tv=%b td=%h se=%b expected tv=1 td=00 se=0", tx_valid, tx_data, seq_err);
        end
        checks++;
        // The dropped write must not alias onto a low address.
        send_frame(2'b10, 8'h00);
        send_frame(2'b11, 8'h00);
        if (tx_data !== exp_td) begin
            errors++;
            $display("FAIL oor_alias: got td=%h expected %h", tx_data, exp_td);
        end
        checks++;
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        send_frame(2'b00, 8'h10);
        send_frame(2'b01, 8'h77);
        send_frame(2'b10, 8'h10);
        send_frame(2'b11, 8'h00);
        if (tx_data !== 8'h77 || tx_valid !== 1'b1 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_read: got tv=%b td=%h se=%b expected tv=1 td=77 se=0", tx_valid, tx_data, seq_err);
        end
        checks++;
        // Write then read of the same address on consecutive edges.
        send_frame(2'b01, 8'h9E);
        send_frame(2'b10, 8'h10);
        send_frame(2'b11, 8'h00);
        send_frame(2'b01, 8'h77);
        if (tx_data !== 8'h9E) begin
            errors++;
            $display("FAIL b2b_raw: got td=%h expected 9e", tx_data);
        end
        checks++;
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        send_frame(2'b10, 8'h10);
        rx_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        if (tx_data !== 8'h00 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got tv=%b td=%h expected tv=0 td=00", tx_valid, tx_data);
        end
        checks++;
        send_frame(2'b11, 8'h00);
        if (tx_data !== m_mem[0] || seq_err !== 1'b1 || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_read0: got tv=%b td=%h se=%b expected tv=1 td=%h se=1", tx_valid, tx_data, seq_err, m_mem[0]);
        end
        checks++;
        send_frame(2'b10, 8'h10);
        send_frame(2'b11, 8'h00);
        if (tx_data !== 8'h77 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_mem10: got td=%h se=%b expected td=77 se=0", tx_data, seq_err);
        end
        checks++;
        idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                send_frame(2'($urandom), 8'($urandom));
            end
            if (tx_valid !== exp_tv || seq_err !== exp_se || tx_data !== exp_td) begin
                errors++;
                $display("FAIL rand%0d: got tv=%b se=%b td=%h expected tv=%b se=%b td=%h",
                         i, tx_valid, seq_err, tx_data, exp_tv, exp_se, exp_td);
            end
            checks++;
        end
        idle_cycle();
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        model_reset();
        test_reset();
        test_basic_rw();
        test_fill();
        test_double_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_spi_ram_ctrl
`default_nettype wire
